// File: rtl/pipe_stage_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_buffer
//  Purpose  : Elastic pipeline-stage register placed between two pipeline
//             stages (e.g. EX -> WB). Holds up to DEPTH entries of
//             {ctrl, data_a, data_b, rd} in a circular FIFO with valid/ready
//             handshaking on both sides, a synchronous flush and masking of
//             the control bundle whenever no valid entry is presented.
//  Ports    :
//    clk         in   rising-edge clock
//    rst_n       in   asynchronous active-low reset
//    flush       in   synchronous discard of every held entry
//    in_valid    in   upstream offers an entry
//    in_ready    out  an entry can be accepted this cycle
//    in_ctrl     in   control bundle        [CTRL_W]
//    in_data_a   in   data word A           [DATA_W]
//    in_data_b   in   data word B           [DATA_W]
//    in_rd       in   destination register  [RD_W]
//    out_valid   out  head entry is valid
//    out_ready   in   downstream consumes the head entry
//    out_ctrl    out  head control, forced to 0 when out_valid=0
//    out_data_a  out  head data word A
//    out_data_b  out  head data word B
//    out_rd      out  head destination register
//    level       out  current occupancy     [$clog2(DEPTH)+1]
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_buffer #(
  parameter int CTRL_W = 7,
  parameter int DATA_W = 33,
  parameter int RD_W   = 6,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_data_a,
  input  logic [DATA_W-1:0]      in_data_b,
  input  logic [RD_W-1:0]        in_rd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_data_a,
  output logic [DATA_W-1:0]      out_data_b,
  output logic [RD_W-1:0]        out_rd,
  output logic [$clog2(DEPTH):0] level
);

  localparam int                 c_PTR_W   = $clog2(DEPTH);
  localparam int                 c_CNT_W   = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  // Storage slots
  logic [CTRL_W-1:0] r_ctrl_mem [DEPTH];
  logic [DATA_W-1:0] r_a_mem    [DEPTH];
  logic [DATA_W-1:0] r_b_mem    [DEPTH];
  logic [RD_W-1:0]   r_rd_mem   [DEPTH];

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  // Handshake status comes only from the registered count, so in_ready
  // never depends on out_ready (no same-cycle pass-through when full).
  assign in_ready  = (r_count < c_FULL);
  assign out_valid = (r_count != '0);
  assign level     = r_count;

  // Flush overrides any transfer presented in the same cycle.
  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & out_ready & ~flush;

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
  // natural rollover of the pointer width implements the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage. Cleared only by reset; flush leaves contents in place
  // because the ctrl mask already hides them while the buffer is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ctrl_mem[i] <= '0;
        r_a_mem[i]    <= '0;
        r_b_mem[i]    <= '0;
        r_rd_mem[i]   <= '0;
      end
    end else if (w_push) begin
      r_ctrl_mem[r_wr_ptr] <= in_ctrl;
      r_a_mem[r_wr_ptr]    <= in_data_a;
      r_b_mem[r_wr_ptr]    <= in_data_b;
      r_rd_mem[r_wr_ptr]   <= in_rd;
    end
  end

  // Head presentation. Control bits are gated so a bubble can never
  // trigger a register write, branch or jump downstream.
  assign out_ctrl   = r_ctrl_mem[r_rd_ptr] & {CTRL_W{out_valid}};
  assign out_data_a = r_a_mem[r_rd_ptr];
  assign out_data_b = r_b_mem[r_rd_ptr];
  assign out_rd     = r_rd_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: doc/pipe_stage_buffer.md
Name: pipe_stage_buffer

Overview:
Parametrised elastic pipeline-stage register that replaces the fixed inter-stage latches between pipeline stages such as EX and WB. It carries a control bundle, two data words and a destination register index. A DEPTH-entry circular FIFO provides valid/ready backpressure, synchronous flush and bubble masking of control bits. One instance is placed per stage boundary; widths are set per boundary.

Parameters:
CTRL_W, 7, width of control bundle (regwrt, branch, btype, jump, memtoreg, neg, zero at EX/WB)
DATA_W, 33, width of each data word (mem data, ALU result)
RD_W, 6, destination register index width
DEPTH, 2, FIFO entries; power of two, >= 2

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous discard of all held entries
in_valid  in  1  upstream has an entry
in_ready  out  1  stage can accept an entry
in_ctrl  in  CTRL_W  control bundle
in_data_a  in  DATA_W  data word A (memory data)
in_data_b  in  DATA_W  data word B (ALU result)
in_rd  in  RD_W  destination register
out_valid  out  1  head entry valid
out_ready  in  1  downstream consumes head
out_ctrl  out  CTRL_W  head control, masked to 0 when out_valid=0
out_data_a  out  DATA_W  head data A
out_data_b  out  DATA_W  head data B
out_rd  out  RD_W  head destination register
level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst_n=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, all storage slots cleared to 0. Outputs: in_ready=1, out_valid=0, level=0, out_ctrl=0, out_data_a=0, out_data_b=0, out_rd=0. Reset asserted mid-transfer drops every entry immediately; there is no partial state.
- Push: occurs when in_valid & in_ready. The payload is written to slot wr_ptr and wr_ptr increments modulo DEPTH, wrapping DEPTH-1 -> 0.
- Pop: occurs when out_valid & out_ready. rd_ptr increments modulo DEPTH.
- in_ready = (count < DEPTH). out_valid = (count != 0). level = count. All three derive combinationally from the registered count.
- Full: in_ready=0 even when out_ready=1 in the same cycle. There is no same-cycle pass-through. Upstream must hold in_valid and its payload stable until accepted.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Empty: no pop can occur. A push into an empty buffer makes out_valid=1 on the next cycle, so minimum latency is 1 cycle.
- Head outputs: out_data_a, out_data_b and out_rd present slot rd_ptr combinationally. out_ctrl = slot ctrl AND out_valid, so a bubble never asserts regwrt, branch, jump or any other control bit.
- Flush: highest priority, synchronous. On the next edge count=0 and wr_ptr=rd_ptr=0. A push or pop presented in the flush cycle is ignored and not counted. Storage contents are not cleared, but out_ctrl reads 0 because out_valid=0.
- Data is never reordered, duplicated or dropped, except by flush or reset.
- Bench assertions: count never exceeds DEPTH and never underflows.

Test Plan:
- Reset then single push: in_ctrl=7'h41, in_data_a=33'h1_0000_0001, in_data_b=33'h0_DEAD_BEEF, in_rd=6'd5, out_ready=1 -> out_valid=1 one cycle later with matching fields and level=1; next cycle out_valid=0, out_ctrl=0.
- Backpressure fill (DEPTH=2): out_ready=0, push A then B -> level=2, in_ready=0; a third push C held 3 cycles is not accepted; raise out_ready -> outputs A, B, C in order, with C accepted the cycle after the first pop.
- Streaming: in_valid=out_ready=1 for 20 cycles with incrementing in_data_b -> one entry per cycle after 1-cycle latency, level constant at 1, pointers wrap with no loss.
- Flush with simultaneous push and pop at level=2 -> next cycle level=0, out_valid=0, out_ctrl=0, in_ready=1; the flushed-cycle push is absent from later output.
- Async reset mid-stream (rst_n low between edges, level=1) -> out_valid=0 and level=0 immediately, before the next edge; streaming resumes cleanly after release.
- DEPTH=4, DATA_W=64 build: random valid/ready toggling for 1000 cycles -> scoreboard shows order preserved, level never exceeds 4, out_ctrl=0 whenever out_valid=0.
